// File: rtl/cascade_counter_chain.sv
// rtl/cascade_counter_chain.sv - cascaded modulo counters with registered readback and done flag
// Build option: define CASCADE_DONE_STICKY_EN to make done hold until clear or reset.
module cascade_counter_chain #(
   parameter int          NUM_STAGES = 8,
   parameter int          STAGE_W    = 16,
   parameter int unsigned MAX_VAL    = (2**STAGE_W) - 1,
   parameter int          SEL_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               enable,
   input  logic               clear,
   input  logic               dir,
   input  logic [SEL_W-1:0]   rd_sel,
   output logic [STAGE_W-1:0] rd_count,
   output logic               chain_tc,
   output logic               done
);

   localparam logic [STAGE_W-1:0] MAX_V = STAGE_W'(MAX_VAL);

   logic [STAGE_W-1:0] cnt_q [NUM_STAGES];
   logic [STAGE_W-1:0] cnt_d [NUM_STAGES];
   logic [STAGE_W-1:0] term;
   logic               carry;
   logic               last_tc;
   logic [STAGE_W-1:0] rd_count_q, rd_count_d;
   logic               done_q, done_d;

   // carry walks the chain so every stage sees its enable in the same cycle
   always_comb begin
      term  = dir ? MAX_V : '0;
      carry = enable;
      for (int i = 0; i < NUM_STAGES; i++) begin
         cnt_d[i] = cnt_q[i];
         if (carry) begin
            if (dir)
               cnt_d[i] = (cnt_q[i] == MAX_V) ? '0 : cnt_q[i] + STAGE_W'(1);
            else
               cnt_d[i] = (cnt_q[i] == '0) ? MAX_V : cnt_q[i] - STAGE_W'(1);
         end
         carry = carry & (cnt_q[i] == term);
         if (clear)
            cnt_d[i] = '0;
      end
      last_tc = carry;
   end

   assign chain_tc = last_tc & ~clear;

   always_comb begin
      rd_count_d = '0;
      if (int'(rd_sel) < NUM_STAGES)
         rd_count_d = cnt_q[rd_sel];
   end

   always_comb begin
`ifdef CASCADE_DONE_STICKY_EN
      done_d = done_q;
      if (clear)
         done_d = 1'b0;
      else if (chain_tc)
         done_d = 1'b1;
`else
      done_d = chain_tc;
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_STAGES; i++)
            cnt_q[i] <= '0;
         rd_count_q <= '0;
         done_q     <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_STAGES; i++)
            cnt_q[i] <= cnt_d[i];
         rd_count_q <= rd_count_d;
         done_q     <= done_d;
      end
   end

   assign rd_count = rd_count_q;
   assign done     = done_q;

endmodule
